// File: rtl/wb_stage_if.sv
// Bus bundle for the dual-issue writeback stage: EX pair and load data in,
// register-file write ports and retired-instruction count out.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic             ex_valid0;
  logic             ex_valid1;
  logic [4:0]       ex_rd0;
  logic [4:0]       ex_rd1;
  logic [31:0]      ex_result0;
  logic [31:0]      ex_result1;
  logic             ex_load0;
  logic [31:0]      dmem_rdata;
  logic             we;
  logic             we2;
  logic [4:0]       writeaddr;
  logic [4:0]       writeaddr2;
  logic [31:0]      writedata;
  logic [31:0]      writedata2;
  logic [CNT_W-1:0] instret;

  modport master (
    output stall, flush, ex_valid0, ex_valid1, ex_rd0, ex_rd1,
           ex_result0, ex_result1, ex_load0, dmem_rdata,
    input  we, we2, writeaddr, writeaddr2, writedata, writedata2, instret
  );

  modport slave (
    input  stall, flush, ex_valid0, ex_valid1, ex_rd0, ex_rd1,
           ex_result0, ex_result1, ex_load0, dmem_rdata,
    output we, we2, writeaddr, writeaddr2, writedata, writedata2, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Dual-issue writeback stage: registers the EX pair, drives two register-file
// write ports once per held entry, and counts retired instructions.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] result;
  } slot_t;

  slot_t            slot0_q, slot0_d;
  slot_t            slot1_q, slot1_d;
  logic             load0_q, load0_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       retire_cnt;
  logic             we2_int;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    load0_d = load0_q;
    done_d  = done_q;
    if (!bus.stall) begin
      slot0_d = '{valid: bus.ex_valid0 & ~bus.flush, rd: bus.ex_rd0, result: bus.ex_result0};
      slot1_d = '{valid: bus.ex_valid1 & ~bus.flush, rd: bus.ex_rd1, result: bus.ex_result1};
      load0_d = bus.ex_load0;
      done_d  = 1'b0;
    end else begin
      // A held entry has had its one write cycle; block further writes and counting.
      done_d = done_q | slot0_q.valid | slot1_q.valid;
    end

    retire_cnt = {1'b0, slot0_q.valid} + {1'b0, slot1_q.valid};
    instret_d  = done_q ? instret_q : instret_q + CNT_W'(retire_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q   <= '0;
      slot1_q   <= '0;
      load0_q   <= 1'b0;
      done_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      load0_q   <= load0_d;
      done_q    <= done_d;
      instret_q <= instret_d;
    end
  end

  // Same destination in both slots: the younger slot 1 owns the write.
  assign we2_int        = slot1_q.valid && (slot1_q.rd != 5'd0) && !done_q;
  assign bus.we2        = we2_int;
  assign bus.we         = slot0_q.valid && (slot0_q.rd != 5'd0) && !done_q &&
                          !(we2_int && (slot0_q.rd == slot1_q.rd));
  assign bus.writeaddr  = slot0_q.rd;
  assign bus.writeaddr2 = slot1_q.rd;
  assign bus.writedata  = load0_q ? bus.dmem_rdata : slot0_q.result;
  assign bus.writedata2 = slot1_q.result;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: a 32-bit counter instance for the
// main scenarios and a 4-bit counter instance for wrap-around.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_instret = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(32)) bus ();
  wb_stage_if #(.CNT_W(4))  bus4 ();

  wb_stage #(.CNT_W(32)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  wb_stage #(.CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic set_ex(input logic v0, input logic [4:0] rd0, input logic [31:0] r0,
                        input logic ld, input logic v1, input logic [4:0] rd1,
                        input logic [31:0] r1);
    bus.ex_valid0  = v0;
    bus.ex_rd0     = rd0;
    bus.ex_result0 = r0;
    bus.ex_load0   = ld;
    bus.ex_valid1  = v1;
    bus.ex_rd1     = rd1;
    bus.ex_result1 = r1;
  endtask

  task automatic idle();
    set_ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.dmem_rdata = 32'h0;
  endtask

  task automatic set_ex4(input logic v0, input logic v1);
    bus4.ex_valid0 = v0;
    bus4.ex_valid1 = v1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    set_ex(1'b1, 5'd1, 32'h1, 1'b0, 1'b1, 5'd2, 32'h2);
    #3;
    checks++;
    if ({bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2,
         bus.instret} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b we2=%b addr=%0d/%0d data=%h/%h instret=%0d, required all 0",
               bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2,
               bus.instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.we, bus.we2, bus.writeaddr, bus.writeaddr2} !== {1'b1, 1'b1, 5'd1, 5'd2}) begin
      errors++;
      $display("FAIL first_capture: we=%b we2=%b addr=%0d/%0d, required 1 1 1/2",
               bus.we, bus.we2, bus.writeaddr, bus.writeaddr2);
    end
    checks++;
    if (bus.instret !== 32'd0) begin
      errors++;
      $display("FAIL first_capture_instret: got %0d required 0", bus.instret);
    end
    idle();
    step();
    exp_instret = 2;
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL first_commit_instret: got %0d required %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_pair();
    set_ex(1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 5'd6, 32'h22);
    step();
    checks++;
    if ({bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2} !==
        {1'b1, 1'b1, 5'd5, 5'd6, 32'h11, 32'h22}) begin
      errors++;
      $display("FAIL pair_write: we=%b we2=%b addr=%0d/%0d data=%h/%h, required 1 1 5/6 11/22",
               bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2);
    end
    idle();
    step();
    exp_instret += 2;
    checks++;
    if ({bus.we, bus.we2} !== 2'b00 || bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL pair_commit: we=%b we2=%b instret=%0d, required 0 0 %0d",
               bus.we, bus.we2, bus.instret, exp_instret);
    end
  endtask

  task automatic test_same_rd();
    set_ex(1'b1, 5'd7, 32'hA, 1'b0, 1'b1, 5'd7, 32'hB);
    step();
    checks++;
    if ({bus.we, bus.we2, bus.writeaddr2, bus.writedata2} !== {1'b0, 1'b1, 5'd7, 32'hB}) begin
      errors++;
      $display("FAIL same_rd: we=%b we2=%b addr2=%0d data2=%h, required 0 1 7 b",
               bus.we, bus.we2, bus.writeaddr2, bus.writedata2);
    end
    idle();
    step();
    exp_instret += 2;
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL same_rd_instret: got %0d required %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_load_stall();
    set_ex(1'b1, 5'd3, 32'h1234, 1'b1, 1'b0, 5'd4, 32'h0);
    step();
    bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({bus.we, bus.writeaddr, bus.writedata} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL load_first_write: we=%b addr=%0d data=%h, required 1 3 deadbeef",
               bus.we, bus.writeaddr, bus.writedata);
    end
    bus.stall = 1'b1;
    set_ex(1'b1, 5'd20, 32'h77, 1'b0, 1'b1, 5'd21, 32'h78);
    for (int i = 0; i < 3; i++) begin
      bus.dmem_rdata = 32'h1000 + i;
      step();
      checks++;
      if ({bus.we, bus.we2, bus.writeaddr} !== {1'b0, 1'b0, 5'd3}) begin
        errors++;
        $display("FAIL load_stall_cycle%0d: we=%b we2=%b addr=%0d, required 0 0 3",
                 i, bus.we, bus.we2, bus.writeaddr);
      end
    end
    idle();
    step();
    exp_instret += 1;
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL load_stall_instret: got %0d required %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_flush();
    set_ex(1'b1, 5'd10, 32'h10, 1'b0, 1'b1, 5'd11, 32'h11);
    bus.flush = 1'b1;
    step();
    checks++;
    if ({bus.we, bus.we2} !== 2'b00) begin
      errors++;
      $display("FAIL flush_we: we=%b we2=%b, required 0 0", bus.we, bus.we2);
    end
    idle();
    step();
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL flush_instret: got %0d required %0d", bus.instret, exp_instret);
    end

    set_ex(1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 5'd9, 32'h99);
    step();
    checks++;
    if ({bus.we, bus.we2} !== 2'b11) begin
      errors++;
      $display("FAIL flush_stall_setup: we=%b we2=%b, required 1 1", bus.we, bus.we2);
    end
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    set_ex(1'b1, 5'd12, 32'hCC, 1'b0, 1'b1, 5'd13, 32'hDD);
    step();
    exp_instret += 2;
    checks++;
    if ({bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2} !==
        {1'b0, 1'b0, 5'd8, 5'd9, 32'h88, 32'h99} || bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL flush_stall_hold: we=%b we2=%b addr=%0d/%0d data=%h/%h instret=%0d, required 0 0 8/9 88/99 %0d",
               bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2,
               bus.instret, exp_instret);
    end
    idle();
    step();
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL flush_stall_instret: got %0d required %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_rd_zero();
    set_ex(1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 5'd4, 32'h66);
    step();
    checks++;
    if ({bus.we, bus.we2} !== 2'b00) begin
      errors++;
      $display("FAIL rd_zero_we: we=%b we2=%b, required 0 0", bus.we, bus.we2);
    end
    idle();
    step();
    exp_instret += 1;
    checks++;
    if (bus.instret !== exp_instret) begin
      errors++;
      $display("FAIL rd_zero_instret: got %0d required %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      set_ex4(1'b1, 1'b1);
      step();
    end
    set_ex4(1'b1, 1'b0);
    step();
    set_ex4(1'b0, 1'b0);
    step();
    checks++;
    if (bus4.instret !== 4'd15) begin
      errors++;
      $display("FAIL wrap_preload: got %0d required 15", bus4.instret);
    end
    set_ex4(1'b1, 1'b1);
    step();
    set_ex4(1'b0, 1'b0);
    step();
    checks++;
    if (bus4.instret !== 4'd1) begin
      errors++;
      $display("FAIL wrap_instret: got %0d required 1", bus4.instret);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_ex(1'b1, 5'd14, 32'hEE, 1'b0, 1'b1, 5'd15, 32'hFF);
    step();
    bus.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2,
         bus.instret, bus4.instret} !== '0) begin
      errors++;
      $display("FAIL reset_async: we=%b we2=%b addr=%0d/%0d data=%h/%h instret=%0d instret4=%0d, required all 0",
               bus.we, bus.we2, bus.writeaddr, bus.writeaddr2, bus.writedata, bus.writedata2,
               bus.instret, bus4.instret);
    end
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.we, bus.we2} !== 2'b00 || bus.instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_drop_entry: we=%b we2=%b instret=%0d, required 0 0 0",
               bus.we, bus.we2, bus.instret);
    end
    idle();
  endtask

  initial begin
    idle();
    bus4.stall      = 1'b0;
    bus4.flush      = 1'b0;
    bus4.ex_rd0     = 5'd1;
    bus4.ex_rd1     = 5'd2;
    bus4.ex_result0 = 32'h0;
    bus4.ex_result1 = 32'h0;
    bus4.ex_load0   = 1'b0;
    bus4.dmem_rdata = 32'h0;
    set_ex4(1'b0, 1'b0);

    test_reset();
    test_pair();
    test_same_rd();
    test_load_stall();
    test_flush();
    test_rd_zero();
    test_wrap();
    test_reset_mid_stall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
